ntt_unload: RTL and testbench

- Reader at the output end of the NTT/INTT core.
- Captures the 8x32 coefficient array the core presents alongside its single-cycle valid pulse.
- Streams the 256 coefficients out one per cycle, in natural index order, over a valid/ready handshake.
- Optionally reduces each coefficient to canonical form [0, q-1] on the way out; feeds the serial pointwise-multiply and compress/encode stages.

---
 rtl/ntt_unload.sv | 114 +++++++++++
 tb/tb_ntt_unload.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ntt_unload.sv
// Output reader for the NTT/INTT core: captures a full 8x32 polynomial in one
// cycle and streams it out coefficient by coefficient over valid/ready.
module ntt_unload #(
  parameter int KYBER_Q = 3329,
  parameter bit REDUCE  = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [0:7][0:31][15:0]   i_data,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic [15:0]              o_data,
  output logic                     o_last,
  input  logic                     i_ready
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [0:7][0:31][15:0]   buf_q;
  logic [15:0]              cur_s;
  logic                     streaming_s;

  // Barrett-style reduction to [0, q-1]; the 32-bit intermediate covers all of int16.
  function automatic logic [15:0] reduce_f(input logic [15:0] x);
    logic signed [31:0] xs;
    logic signed [31:0] t;
    logic signed [31:0] r;
    xs = {{16{x[15]}}, x};
    t  = (xs * 32'sd20159 + 32'sd33554432) >>> 26;
    r  = xs - t * KYBER_Q;
    if (r < 32'sd0) begin
      r = r + KYBER_Q;
    end else begin
      r = r;
    end
    return {4'b0000, 12'(r)};
  endfunction

  assign streaming_s = (state_q == S_STREAM);
  assign cur_s       = buf_q[cnt_q[7:5]][cnt_q[4:0]];

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_STREAM;
          cnt_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (i_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd255) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture only from idle so a pulse arriving mid-stream leaves the buffer intact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q <= '0;
    end else if (!streaming_s && i_valid) begin
      buf_q <= i_data;
    end else begin
      buf_q <= buf_q;
    end
  end

  // Output mux driven from registers only, never from i_ready.
  always_comb begin
    o_valid = streaming_s;
    o_busy  = streaming_s;
    o_last  = streaming_s && (cnt_q == 8'd255);
    if (!streaming_s) begin
      o_data = 16'd0;
    end else if (REDUCE) begin
      o_data = reduce_f(cur_s);
    end else begin
      o_data = cur_s;
    end
  end

endmodule

// File: tb/tb_ntt_unload.sv
// Directed bench for ntt_unload: one reducing and one raw instance share stimulus.
module tb_ntt_unload;

  logic                   clk;
  logic                   rst_n;
  logic                   valid;
  logic                   ready;
  logic [0:7][0:31][15:0] data;
  logic                   r_busy, r_valid, r_last;
  logic [15:0]            r_data;
  logic                   w_busy, w_valid, w_last;
  logic [15:0]            w_data;

  int n_checks = 0;
  int n_fail   = 0;

  ntt_unload #(.KYBER_Q(3329), .REDUCE(1'b1)) u_red (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .o_busy(r_busy), .o_valid(r_valid), .o_data(r_data), .o_last(r_last),
    .i_ready(ready)
  );

  ntt_unload #(.KYBER_Q(3329), .REDUCE(1'b0)) u_raw (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .o_busy(w_busy), .o_valid(w_valid), .o_data(w_data), .o_last(w_last),
    .i_ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {15'd0, r_valid}, 16'd0);
    chk({tag, "_busy"},  {15'd0, r_busy},  16'd0);
    chk({tag, "_data"},  r_data,           16'd0);
    chk({tag, "_last"},  {15'd0, r_last},  16'd0);
  endtask

  task automatic set_lin(input int offset, input int mult);
    for (int k = 0; k < 256; k++) data[k / 32][k % 32] = 16'(offset + mult * k);
  endtask

  task automatic pulse();
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    ready = 1'b1;
    while (r_busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_done", {15'd0, r_busy}, 16'd0);
  endtask

  initial begin
    int idx;
    int xfers;
    int cyc;
    rst_n = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    data  = '0;

    // Reset and quiet idle.
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", {15'd0, r_valid}, 16'd0);
      chk("idle_busy",  {15'd0, r_busy},  16'd0);
      chk("idle_data",  r_data,           16'd0);
    end

    // Natural-order ramp at full throughput.
    set_lin(0, 1);
    ready = 1'b1;
    pulse();
    for (int k = 0; k < 256; k++) begin
      chk("ramp_valid", {15'd0, r_valid}, 16'd1);
      chk("ramp_busy",  {15'd0, r_busy},  16'd1);
      chk("ramp_data",  r_data, 16'(k));
      chk("ramp_raw",   w_data, 16'(k));
      chk("ramp_last",  {15'd0, r_last}, {15'd0, (k == 255)});
      @(negedge clk);
    end
    chk_idle("ramp_end");

    // Boundary values through both reduction settings.
    set_lin(0, 0);
    data[0][0] = 16'hFFFF;
    data[0][1] = 16'd3329;
    data[0][2] = 16'h7FFF;
    data[0][3] = 16'h8000;
    data[0][4] = 16'd0;
    data[0][5] = 16'd3328;
    pulse();
    chk("bnd_red0", r_data, 16'd3328);  chk("bnd_raw0", w_data, 16'hFFFF);  @(negedge clk);
    chk("bnd_red1", r_data, 16'd0);     chk("bnd_raw1", w_data, 16'd3329);  @(negedge clk);
    chk("bnd_red2", r_data, 16'd2806);  chk("bnd_raw2", w_data, 16'h7FFF);  @(negedge clk);
    chk("bnd_red3", r_data, 16'd522);   chk("bnd_raw3", w_data, 16'h8000);  @(negedge clk);
    chk("bnd_red4", r_data, 16'd0);     chk("bnd_raw4", w_data, 16'd0);     @(negedge clk);
    chk("bnd_red5", r_data, 16'd3328);  chk("bnd_raw5", w_data, 16'd3328);
    drain();

    // Random backpressure; values stay below q so both instances agree.
    set_lin(0, 13);
    ready = 1'b0;
    pulse();
    idx   = 0;
    xfers = 0;
    cyc   = 0;
    while (cyc < 2000) begin
      if (!r_valid) begin
        chk("bp_no_early_drop", 16'(xfers), 16'd256);
        break;
      end
      if (r_data !== 16'(idx * 13) || w_data !== 16'(idx * 13) || r_last !== (idx == 255)) begin
        chk("bp_data", r_data, 16'(idx * 13));
        chk("bp_last", {15'd0, r_last}, {15'd0, (idx == 255)});
      end
      ready = 1'($urandom_range(0, 1));
      if (ready) begin
        idx++;
        xfers++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("bp_xfers", 16'(xfers), 16'd256);
    chk_idle("bp_end");

    // Pulses mid-stream and on the final transfer are ignored.
    set_lin(0, 1);
    ready = 1'b1;
    pulse();
    for (int k = 0; k < 256; k++) begin
      chk("mid_data", r_data, 16'(k));
      if (k == 100 || k == 255) begin
        set_lin(1000, 1);
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    chk_idle("mid_end");
    pulse();
    for (int k = 0; k < 4; k++) begin
      chk("second_data", r_data, 16'(1000 + k));
      @(negedge clk);
    end
    drain();

    // Asynchronous reset mid-stream, then a fresh capture.
    set_lin(0, 1);
    pulse();
    for (int k = 0; k < 37; k++) @(negedge clk);
    chk("pre_rst_data", r_data, 16'd37);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    set_lin(500, 2);
    pulse();
    for (int k = 0; k < 4; k++) begin
      chk("fresh_data", r_data, 16'(500 + 2 * k));
      @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
